// File: rtl/hexdisp_pkg.sv
// Shared definitions for the hex status display: segment patterns, display codes,
// the fmode mantissa/exponent table and the controller state encoding.
package hexdisp_pkg;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ALL   = 7'b0000000;

  // Symbol codes fed to seg7_encode; 0..9 are the decimal digits themselves
  localparam logic [3:0] CODE_E     = 4'd10;
  localparam logic [3:0] CODE_P     = 4'd11;
  localparam logic [3:0] CODE_DASH  = 4'd12;
  localparam logic [3:0] CODE_BLANK = 4'd13;
  localparam logic [3:0] CODE_ALL   = 4'd14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLINK = 2'd1,
    LAMP  = 2'd2
  } state_t;

  // Sample rate as mantissa x 10^exponent, returned as {mantissa, exponent} codes
  function automatic logic [7:0] fmode_digits(input logic [2:0] f);
    logic [7:0] r;
    case (f)
      3'd0:    r = {4'd1, 4'd3};
      3'd1:    r = {4'd5, 4'd3};
      3'd2:    r = {4'd1, 4'd4};
      3'd3:    r = {4'd5, 4'd4};
      3'd4:    r = {4'd1, 4'd5};
      3'd5:    r = {4'd5, 4'd5};
      3'd6:    r = {4'd1, 4'd6};
      default: r = {4'd2, 4'd6};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational digit/symbol code to active-low 7-segment pattern.
module seg7_encode
  import hexdisp_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:       seg = SEG_0;
      4'd1:       seg = SEG_1;
      4'd2:       seg = SEG_2;
      4'd3:       seg = SEG_3;
      4'd4:       seg = SEG_4;
      4'd5:       seg = SEG_5;
      4'd6:       seg = SEG_6;
      4'd7:       seg = SEG_7;
      4'd8:       seg = SEG_8;
      4'd9:       seg = SEG_9;
      CODE_E:     seg = SEG_E;
      CODE_P:     seg = SEG_P;
      CODE_DASH:  seg = SEG_DASH;
      CODE_BLANK: seg = SEG_BLANK;
      CODE_ALL:   seg = SEG_ALL;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_status_display.sv
// Registered sample-rate / PAM-mode display on HEX7..HEX0 with blink-on-change.
// Define HEXCTRL_LAMP_TEST_EN to add a post-reset lamp test (all segments lit).
//
// state | meaning
// IDLE  | decoded fields shown steadily
// BLINK | changed fields blank during OFF half-periods
// LAMP  | post-reset lamp test, every segment lit
module hex_status_display
  import hexdisp_pkg::*;
#(
  parameter int MMODE_W       = 3,
  parameter int HALF_PERIOD   = 12500000,
  parameter int BLINK_TOGGLES = 6,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         fmode,
  input  logic [MMODE_W-1:0] mmode,
  output logic [6:0]         HEX7,
  output logic [6:0]         HEX6,
  output logic [6:0]         HEX5,
  output logic [6:0]         HEX4,
  output logic [6:0]         HEX3,
  output logic [6:0]         HEX2,
  output logic [6:0]         HEX1,
  output logic [6:0]         HEX0,
  output logic               blinking
);

  // Prescaler is sized for the lamp test (2 half-periods) so both builds share it
  localparam int PW = $clog2(2 * HALF_PERIOD + 1);
  localparam int TW = $clog2(BLINK_TOGGLES);
  localparam logic [PW-1:0] HP_LAST  = PW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] TOG_LAST = TW'(BLINK_TOGGLES - 1);
  localparam logic [6:0]    POL      = (ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
`ifdef HEXCTRL_LAMP_TEST_EN
  localparam logic [PW-1:0] LAMP_LAST = PW'(2 * HALF_PERIOD - 1);
  localparam state_t        RST_STATE = LAMP;
`else
  localparam state_t        RST_STATE = IDLE;
`endif

  state_t             state_q, state_d;
  logic [1:0]         mask_q, mask_d;      // {frequency, modulation}
  logic               phase_on_q, phase_on_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [TW-1:0]      tog_q, tog_d;
  logic [2:0]         fmode_q;
  logic [MMODE_W-1:0] mmode_q;
  logic               f_chg, m_chg;

  assign f_chg = (fmode != fmode_q);
  assign m_chg = (mmode != mmode_q);

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    phase_on_d = phase_on_q;
    presc_d    = presc_q;
    tog_d      = tog_q;
    case (state_q)
      IDLE: begin
        if (f_chg || m_chg) begin
          state_d    = BLINK;
          mask_d     = {f_chg, m_chg};
          phase_on_d = 1'b1;
          presc_d    = '0;
          tog_d      = '0;
        end
      end
      BLINK: begin
        if (f_chg || m_chg) begin
          mask_d     = mask_q | {f_chg, m_chg};
          phase_on_d = 1'b1;
          presc_d    = '0;
          tog_d      = '0;
        end else if (presc_q == HP_LAST) begin
          presc_d    = '0;
          phase_on_d = ~phase_on_q;
          if (tog_q == TOG_LAST) begin
            // Even toggle count, so the episode always ends in the ON phase
            state_d    = IDLE;
            mask_d     = 2'b00;
            phase_on_d = 1'b1;
            tog_d      = '0;
          end else begin
            tog_d = tog_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      LAMP: begin
`ifdef HEXCTRL_LAMP_TEST_EN
        if (presc_q == LAMP_LAST) begin
          state_d = IDLE;
          presc_d = '0;
        end else begin
          presc_d = presc_q + 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  logic [3:0]  code    [8];
  logic [6:0]  seg_raw [8];
  logic [7:0]  fdig;
  logic [31:0] mm_ext;
  logic        f_off, m_off;

  always_comb begin
    fdig   = fmode_digits(fmode_q);
    mm_ext = 32'(mmode_q);
    f_off  = (state_q == BLINK) && !phase_on_q && mask_q[1];
    m_off  = (state_q == BLINK) && !phase_on_q && mask_q[0];
    code[7] = CODE_BLANK;
    code[6] = fdig[7:4];
    code[5] = CODE_E;
    code[4] = fdig[3:0];
    code[3] = CODE_P;
    code[2] = CODE_DASH;
    case (mm_ext)
      32'd0:   begin code[1] = 4'd4; code[0] = CODE_BLANK; end
      32'd1:   begin code[1] = 4'd8; code[0] = CODE_BLANK; end
      32'd2:   begin code[1] = 4'd1; code[0] = 4'd6;       end
      32'd3:   begin code[1] = 4'd3; code[0] = 4'd2;       end
      32'd4:   begin code[1] = 4'd6; code[0] = 4'd4;       end
      default: begin code[1] = CODE_DASH; code[0] = CODE_DASH; end
    endcase
    if (state_q == LAMP) begin
      for (int i = 0; i < 8; i++) code[i] = CODE_ALL;
    end else begin
      if (f_off) for (int i = 4; i < 8; i++) code[i] = CODE_BLANK;
      if (m_off) for (int i = 0; i < 4; i++) code[i] = CODE_BLANK;
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_dig
    seg7_encode u_enc (
      .code (code[g]),
      .seg  (seg_raw[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST_STATE;
      mask_q     <= 2'b00;
      phase_on_q <= 1'b1;
      presc_q    <= '0;
      tog_q      <= '0;
      fmode_q    <= fmode;
      mmode_q    <= mmode;
      HEX7       <= SEG_BLANK ^ POL;
      HEX6       <= SEG_BLANK ^ POL;
      HEX5       <= SEG_BLANK ^ POL;
      HEX4       <= SEG_BLANK ^ POL;
      HEX3       <= SEG_BLANK ^ POL;
      HEX2       <= SEG_BLANK ^ POL;
      HEX1       <= SEG_BLANK ^ POL;
      HEX0       <= SEG_BLANK ^ POL;
      blinking   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      phase_on_q <= phase_on_d;
      presc_q    <= presc_d;
      tog_q      <= tog_d;
      fmode_q    <= fmode;
      mmode_q    <= mmode;
      HEX7       <= seg_raw[7] ^ POL;
      HEX6       <= seg_raw[6] ^ POL;
      HEX5       <= seg_raw[5] ^ POL;
      HEX4       <= seg_raw[4] ^ POL;
      HEX3       <= seg_raw[3] ^ POL;
      HEX2       <= seg_raw[2] ^ POL;
      HEX1       <= seg_raw[1] ^ POL;
      HEX0       <= seg_raw[0] ^ POL;
      blinking   <= (state_q == BLINK);
    end
  end

endmodule
